uart_tx_ctrl: RTL and testbench

- Transmit-side controller for the 16550 UART.
- Buffers host writes to the transmit holding register in a FIFO: DEPTH entries in FIFO mode, 1 entry in non-FIFO mode.
- Feeds bytes one at a time into the serial transmitter using its tx_start/tx_busy handshake, and holds each byte stable until the transmitter has consumed it.
- Produces the THRE and TEMT line-status flags and supports flow-control pause and FIFO flush.

---
 rtl/uart_tx_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - 16550 transmit controller: THR FIFO, launch FSM, THRE/TEMT flags
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   wr_data      byte written to THR
//   wr_en        one-cycle THR write strobe
//   fifo_en      1 = FIFO mode (DEPTH entries), 0 = 16450 mode (1 entry)
//   fifo_clr     one-cycle FIFO flush strobe
//   tx_pause     hold off new launches (CTS flow control)
//   tx_busy      serial transmitter busy
//   tx_data      byte presented to the transmitter, held until the next pop
//   tx_start     one-cycle launch request
//   thre         holding register / FIFO empty
//   temt         FIFO empty and transmitter idle
//   fifo_count   entries currently stored
//   wr_drop      one-cycle pulse when a write hit a full FIFO
module uart_tx_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          fifo_en,
    input  logic          fifo_clr,
    input  logic          tx_pause,
    input  logic          tx_busy,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    output logic          thre,
    output logic          temt,
    output logic [AW:0]   fifo_count,
    output logic          wr_drop
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_en_q;

    logic          flush;
    logic [AW:0]   cap;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW:0]   count_next;

    // A mode switch reshapes the buffer, so it is treated exactly like an FCR flush.
    assign flush = fifo_clr | (fifo_en ^ fifo_en_q);
    assign cap   = fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
    assign full  = (fifo_count == cap);

    // Flushed writes vanish silently; only a genuine overflow reports wr_drop.
    assign push  = wr_en & ~full & ~flush;
    assign drop  = wr_en &  full & ~flush;
    assign pop   = (state == IDLE) & (fifo_count != '0) & ~tx_pause & ~flush;

    always_comb begin
        count_next = fifo_count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = fifo_count + (AW+1)'(1);
                2'b01:   count_next = fifo_count - (AW+1)'(1);
                default: count_next = fifo_count;
            endcase
        end
    end

    assign temt = thre & (state == IDLE) & ~tx_busy;

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            thre       <= 1'b1;
            wr_drop    <= 1'b0;
            fifo_en_q  <= 1'b0;
            state      <= IDLE;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
        end else begin
            fifo_en_q  <= fifo_en;
            wr_drop    <= drop;
            fifo_count <= count_next;
            thre       <= (count_next == '0);

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end

            // A byte already handed off keeps going through a flush.
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    tx_start <= 1'b0;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed, table-driven bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       fifo_en = 1'b0;
    logic       fifo_clr = 1'b0;
    logic       tx_pause = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       thre;
    logic       temt;
    logic [4:0] fifo_count;
    logic       wr_drop;

    uart_tx_ctrl #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .fifo_en    (fifo_en),
        .fifo_clr   (fifo_clr),
        .tx_pause   (tx_pause),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .thre       (thre),
        .temt       (temt),
        .fifo_count (fifo_count),
        .wr_drop    (wr_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Serial transmitter model: busy rises the cycle after tx_start, lasts busy_len cycles.
    int   busy_len = 4;
    int   busy_rem = 0;
    logic xmit_en = 1'b1;

    always @(posedge clk) begin
        if (tx_start && xmit_en && rst_n) begin
            tx_busy  <= 1'b1;
            busy_rem <= busy_len;
        end else if (tx_busy) begin
            if (busy_rem <= 1) tx_busy <= 1'b0;
            else busy_rem <= busy_rem - 1;
        end
    end

    logic [7:0] sent_q[$];
    logic [7:0] launched = 8'h00;
    int         stab_err = 0;

    always @(posedge clk) begin
        if (rst_n && tx_start) begin
            sent_q.push_back(tx_data);
            launched = tx_data;
        end else if (rst_n && tx_busy && tx_data !== launched) begin
            stab_err = stab_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sent(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (sent_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        if (sent_q.size() < n) begin
            n_cmp = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: timeout, sent %0d expected %0d", name, sent_q.size(), n);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       fifo_en;
        logic       fifo_clr;
        logic       tx_pause;
        logic [4:0] exp_count;
        logic       exp_thre;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            wr_en    = vecs[i].wr_en;
            wr_data  = vecs[i].wr_data;
            fifo_en  = vecs[i].fifo_en;
            fifo_clr = vecs[i].fifo_clr;
            tx_pause = vecs[i].tx_pause;
            cycle();
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_thre", i), 32'(thre), 32'(vecs[i].exp_thre));
            check($sformatf("vec%0d_drop", i), 32'(wr_drop), 32'(vecs[i].exp_drop));
        end
        @(negedge clk);
        wr_en = 1'b0;
        fifo_clr = 1'b0;
    endtask

    initial begin
        int base;
        int k;
        vec_t v;

        // Vectors 0..17: fill a 16-entry FIFO under pause, 17th write (0x10) drops.
        for (int i = 0; i < 17; i++) begin
            v = '{1'b1, 8'(i), 1'b1, 1'b0, 1'b1, (i >= 15) ? 5'd16 : 5'(i + 1), 1'b0, (i == 16)};
            vecs.push_back(v);
        end
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0});
        // Vectors 18..21: switch to 16450 mode (implicit flush), then one slot only.
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0});

        // Reset state
        #22;
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_thre", 32'(thre), 32'd1);
        check("rst_temt", 32'(temt), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_drop", 32'(wr_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fifo_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte, long transmitter busy
        busy_len = 100;
        base = sent_q.size();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        cycle();
        check("single_count_after_write", 32'(fifo_count), 32'd1);
        check("single_no_start_yet", 32'(tx_start), 32'd0);
        wr_en = 1'b0;
        cycle();
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_thre_after_pop", 32'(thre), 32'd1);
        cycle();
        check("single_start_one_cycle", 32'(tx_start), 32'd0);
        check("single_temt_busy", 32'(temt), 32'd0);
        k = 0;
        while (!tx_busy && k < 5) begin cycle(); k++; end
        while (tx_busy && k < 200) begin cycle(); k++; end
        check("single_busy_fell", 32'(tx_busy), 32'd0);
        check("single_temt_same_cycle", 32'(temt), 32'd0);
        cycle();
        check("single_temt_next_cycle", 32'(temt), 32'd1);
        check("single_sent_n", 32'(sent_q.size() - base), 32'd1);

        // Full FIFO with pause, then drain
        busy_len = 4;
        base = sent_q.size();
        apply_vecs(0, 18);
        tx_pause = 1'b0;
        wait_sent(base + 16, 400, "full_drain");
        repeat (40) cycle();
        check("full_sent_n", 32'(sent_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < sent_q.size())
                check($sformatf("full_byte%0d", i), 32'(sent_q[base + i]), 32'(i));
        end
        check("full_empty_after", 32'(fifo_count), 32'd0);

        // Non-FIFO mode
        base = sent_q.size();
        apply_vecs(18, 22);
        tx_pause = 1'b0;
        wait_sent(base + 1, 50, "nonfifo_drain");
        repeat (30) cycle();
        check("nonfifo_sent_n", 32'(sent_q.size() - base), 32'd1);
        if (sent_q.size() > base) check("nonfifo_byte", 32'(sent_q[base]), 32'h11);

        @(negedge clk);
        fifo_en = 1'b1;
        repeat (3) @(negedge clk);

        // Flush while the first of three bytes is in WAIT_DONE
        busy_len = 20;
        tx_pause = 1'b1;
        base = sent_q.size();
        write_byte(8'hB1);
        write_byte(8'hB2);
        write_byte(8'hB3);
        tx_pause = 1'b0;
        wait_sent(base + 1, 20, "flush_first_start");
        k = 0;
        while (!tx_busy && k < 5) begin cycle(); k++; end
        repeat (2) cycle();
        check("flush_count_before", 32'(fifo_count), 32'd2);
        @(negedge clk);
        fifo_clr = 1'b1;
        cycle();
        check("flush_count_zero", 32'(fifo_count), 32'd0);
        check("flush_thre", 32'(thre), 32'd1);
        fifo_clr = 1'b0;
        repeat (50) cycle();
        check("flush_sent_n", 32'(sent_q.size() - base), 32'd1);
        if (sent_q.size() > base) check("flush_byte", 32'(sent_q[base]), 32'hB1);
        check("flush_temt", 32'(temt), 32'd1);

        // Simultaneous push and pop
        busy_len = 4;
        base = sent_q.size();
        @(negedge clk);
        tx_pause = 1'b1;
        write_byte(8'h5A);
        tx_pause = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h3C;
        cycle();
        check("pushpop_count", 32'(fifo_count), 32'd1);
        check("pushpop_start", 32'(tx_start), 32'd1);
        check("pushpop_data", 32'(tx_data), 32'h5A);
        wr_en = 1'b0;
        wait_sent(base + 2, 60, "pushpop_drain");
        if (sent_q.size() >= base + 2) check("pushpop_second", 32'(sent_q[base + 1]), 32'h3C);

        // Asynchronous reset while in WAIT_ACK
        repeat (10) cycle();
        xmit_en = 1'b0;
        base = sent_q.size();
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        wr_data = 8'h88;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check("ack_count_before_rst", 32'(fifo_count), 32'd1);
        check("ack_no_busy", 32'(tx_busy), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_start", 32'(tx_start), 32'd0);
        check("arst_thre", 32'(thre), 32'd1);
        check("arst_temt", 32'(temt), 32'd1);
        check("arst_count", 32'(fifo_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xmit_en = 1'b1;
        base = sent_q.size();
        repeat (3) @(negedge clk);
        check("arst_no_relaunch", 32'(sent_q.size() - base), 32'd0);
        write_byte(8'h99);
        wait_sent(base + 1, 20, "arst_resume");
        if (sent_q.size() > base) check("arst_resume_byte", 32'(sent_q[base]), 32'h99);
        repeat (20) cycle();

        check("tx_data_stable_while_busy", 32'(stab_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
